// File: rtl/vram_line_drawer.sv
// Touch-driven stroke rasteriser: clears a 16-bit framebuffer, then draws Bresenham lines
// between successive touch samples, issuing one registered VRAM pixel write per clock.
module vram_line_drawer #(
  parameter int          DISPLAY_WIDTH  = 240,
  parameter int          DISPLAY_HEIGHT = 320,
  parameter logic [15:0] BG_COLOR       = 16'h0000
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            touch_valid,
  input  logic [9:0]                                      touch_x,
  input  logic [9:0]                                      touch_y,
  input  logic [15:0]                                     pen_color,
  input  logic                                            clear_req,
  output logic                                            vram_wr_ena,
  output logic [$clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT)-1:0] vram_wr_addr,
  output logic [15:0]                                     vram_wr_data,
  output logic                                            busy
);

  localparam int              VRAM_L     = DISPLAY_WIDTH * DISPLAY_HEIGHT;
  localparam int              AW         = $clog2(VRAM_L);
  localparam logic [9:0]      X_MAX      = 10'(DISPLAY_WIDTH - 1);
  localparam logic [9:0]      Y_MAX      = 10'(DISPLAY_HEIGHT - 1);
  localparam logic [AW-1:0]   LAST_ADDR  = AW'(VRAM_L - 1);
  localparam logic [AW-1:0]   ROW_STRIDE = AW'(DISPLAY_WIDTH);

  typedef enum logic [1:0] {CLEAR, IDLE, LINE} state_t;

  state_t             state_q;
  logic [AW-1:0]      clr_addr_q;
  logic               pen_down_q;
  logic               clr_pend_q;
  logic [9:0]         last_x_q, last_y_q;
  logic [9:0]         x_q, y_q, x1_q, y1_q;
  logic               sx_neg_q, sy_neg_q;
  logic signed [11:0] dx_q, dy_q, err_q;
  logic [15:0]        color_q;
  logic               wr_ena_q;
  logic [AW-1:0]      wr_addr_q;
  logic [15:0]        wr_data_q;
  logic               busy_q;

  logic [9:0]         cx_d, cy_d, x0_d, y0_d, adx_d, ady_d;
  logic signed [11:0] dx_d, dy_d, e2_d, err_d;
  logic               same_pt_d, clr_go_d, at_end_d, step_x_d, step_y_d;
  logic [AW-1:0]      line_addr_d;

  always_comb begin
    cx_d        = (touch_x > X_MAX) ? X_MAX : touch_x;
    cy_d        = (touch_y > Y_MAX) ? Y_MAX : touch_y;
    // With the pen already down the stroke continues from the previous endpoint.
    x0_d        = pen_down_q ? last_x_q : cx_d;
    y0_d        = pen_down_q ? last_y_q : cy_d;
    adx_d       = (cx_d >= x0_d) ? (cx_d - x0_d) : (x0_d - cx_d);
    ady_d       = (cy_d >= y0_d) ? (cy_d - y0_d) : (y0_d - cy_d);
    dx_d        = $signed({2'b00, adx_d});
    dy_d        = -$signed({2'b00, ady_d});
    same_pt_d   = pen_down_q && (cx_d == last_x_q) && (cy_d == last_y_q);
    clr_go_d    = clear_req || clr_pend_q;
    at_end_d    = (x_q == x1_q) && (y_q == y1_q);
    e2_d        = err_q <<< 1;
    step_x_d    = (e2_d >= dy_q);
    step_y_d    = (e2_d <= dx_q);
    err_d       = err_q + (step_x_d ? dy_q : 12'sd0) + (step_y_d ? dx_q : 12'sd0);
    line_addr_d = AW'(y_q) * ROW_STRIDE + AW'(x_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      pen_down_q <= 1'b0;
      clr_pend_q <= 1'b0;
      last_x_q   <= '0;
      last_y_q   <= '0;
      x_q        <= '0;
      y_q        <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      sx_neg_q   <= 1'b0;
      sy_neg_q   <= 1'b0;
      dx_q       <= '0;
      dy_q       <= '0;
      err_q      <= '0;
      color_q    <= BG_COLOR;
      wr_ena_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= BG_COLOR;
      busy_q     <= 1'b1;
    end else begin
      wr_ena_q <= 1'b0;
      if (!touch_valid) pen_down_q <= 1'b0;
      // Remember a clear request; the branch that starts the clear consumes it.
      if (clear_req) clr_pend_q <= 1'b1;

      unique case (state_q)
        CLEAR: begin
          wr_ena_q  <= 1'b1;
          wr_addr_q <= clr_addr_q;
          wr_data_q <= BG_COLOR;
          if (clr_addr_q == LAST_ADDR) begin
            clr_addr_q <= '0;
            if (clr_go_d) begin
              clr_pend_q <= 1'b0;
              pen_down_q <= 1'b0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            clr_addr_q <= clr_addr_q + AW'(1);
          end
        end

        IDLE: begin
          if (clear_req) begin
            state_q    <= CLEAR;
            busy_q     <= 1'b1;
            clr_addr_q <= '0;
            clr_pend_q <= 1'b0;
            pen_down_q <= 1'b0;
          end else if (touch_valid) begin
            pen_down_q <= 1'b1;
            last_x_q   <= cx_d;
            last_y_q   <= cy_d;
            color_q    <= pen_color;
            if (!same_pt_d) begin
              x_q      <= x0_d;
              y_q      <= y0_d;
              x1_q     <= cx_d;
              y1_q     <= cy_d;
              sx_neg_q <= (cx_d < x0_d);
              sy_neg_q <= (cy_d < y0_d);
              dx_q     <= dx_d;
              dy_q     <= dy_d;
              err_q    <= dx_d + dy_d;
              state_q  <= LINE;
              busy_q   <= 1'b1;
            end
          end
        end

        LINE: begin
          wr_ena_q  <= 1'b1;
          wr_addr_q <= line_addr_d;
          wr_data_q <= color_q;
          if (at_end_d) begin
            if (clr_go_d) begin
              state_q    <= CLEAR;
              clr_addr_q <= '0;
              clr_pend_q <= 1'b0;
              pen_down_q <= 1'b0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            err_q <= err_d;
            if (step_x_d) x_q <= sx_neg_q ? (x_q - 10'd1) : (x_q + 10'd1);
            if (step_y_d) y_q <= sy_neg_q ? (y_q - 10'd1) : (y_q + 10'd1);
          end
        end

        default: begin
          state_q    <= CLEAR;
          clr_addr_q <= '0;
          busy_q     <= 1'b1;
        end
      endcase
    end
  end

  assign vram_wr_ena  = wr_ena_q;
  assign vram_wr_addr = wr_addr_q;
  assign vram_wr_data = wr_data_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_vram_line_drawer.sv
// Bench for vram_line_drawer on a 240x24 panel with a non-zero background colour,
// comparing every VRAM write against a Bresenham / pen-state reference model.
module tb_vram_line_drawer;

  localparam int          W  = 240;
  localparam int          H  = 24;
  localparam int          VL = W * H;
  localparam int          AW = $clog2(VL);
  localparam logic [15:0] BG = 16'h18E3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          touch_valid = 1'b0;
  logic [9:0]    touch_x = '0;
  logic [9:0]    touch_y = '0;
  logic [15:0]   pen_color = '0;
  logic          clear_req = 1'b0;
  logic          vram_wr_ena;
  logic [AW-1:0] vram_wr_addr;
  logic [15:0]   vram_wr_data;
  logic          busy;

  vram_line_drawer #(
    .DISPLAY_WIDTH (W),
    .DISPLAY_HEIGHT(H),
    .BG_COLOR      (BG)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .touch_valid (touch_valid),
    .touch_x     (touch_x),
    .touch_y     (touch_y),
    .pen_color   (pen_color),
    .clear_req   (clear_req),
    .vram_wr_ena (vram_wr_ena),
    .vram_wr_addr(vram_wr_addr),
    .vram_wr_data(vram_wr_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int data; int cyc; } wr_t;
  wr_t wr_q[$];
  wr_t exp_q[$];
  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;
  bit  pen_down_m = 1'b0;
  int  last_x_m = 0;
  int  last_y_m = 0;
  int  exp_px = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk)
    if (vram_wr_ena === 1'b1)
      wr_q.push_back('{int'(vram_wr_addr), int'(vram_wr_data), cyc});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int got_addr(input int i);
    return (i < wr_q.size()) ? wr_q[i].addr : -1;
  endfunction

  task automatic ref_line(input int x0, input int y0, input int x1, input int y1, input int c);
    int x, y, dx, dy, sx, sy, err, e2;
    x   = x0;
    y   = y0;
    dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy  = -((y1 > y0) ? y1 - y0 : y0 - y1);
    sx  = (x0 < x1) ? 1 : -1;
    sy  = (y0 < y1) ? 1 : -1;
    err = dx + dy;
    while (1) begin
      exp_q.push_back('{y * W + x, c, 0});
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  task automatic add_clear();
    for (int i = 0; i < VL; i++) exp_q.push_back('{i, int'(BG), 0});
  endtask

  // Pen-state model of one accepted touch sample.
  task automatic model_accept(input int tx, input int ty, input int c);
    int cx, cy, x0, y0, adx, ady;
    cx = (tx > W - 1) ? W - 1 : tx;
    cy = (ty > H - 1) ? H - 1 : ty;
    if (pen_down_m && cx == last_x_m && cy == last_y_m) begin
      exp_px = 0;
    end else begin
      x0  = pen_down_m ? last_x_m : cx;
      y0  = pen_down_m ? last_y_m : cy;
      adx = (cx > x0) ? cx - x0 : x0 - cx;
      ady = (cy > y0) ? cy - y0 : y0 - cy;
      exp_px = ((adx > ady) ? adx : ady) + 1;
      ref_line(x0, y0, cx, cy, c);
    end
    pen_down_m = 1'b1;
    last_x_m   = cx;
    last_y_m   = cy;
  endtask

  task automatic wait_quiet(input int budget, input string tag, output int busy_cyc);
    int quiet, n;
    quiet    = 0;
    n        = 0;
    busy_cyc = 0;
    while (quiet < 3 && n < budget) begin
      @(negedge clk);
      n++;
      if (busy === 1'b1) busy_cyc++;
      if (busy === 1'b0 && vram_wr_ena === 1'b0) quiet++;
      else quiet = 0;
    end
    check({tag, " settled within budget"}, 32'(n < budget), 1);
  endtask

  task automatic compare_writes(input string tag, input bit consec);
    int bad;
    bad = 0;
    check({tag, " write count"}, wr_q.size(), exp_q.size());
    foreach (exp_q[i])
      if (i >= wr_q.size() || wr_q[i].addr != exp_q[i].addr || wr_q[i].data != exp_q[i].data)
        bad++;
    check({tag, " bad writes"}, bad, 0);
    if (consec && wr_q.size() > 0)
      check({tag, " back-to-back span"}, wr_q[wr_q.size()-1].cyc - wr_q[0].cyc, wr_q.size() - 1);
  endtask

  task automatic stroke(input int tx, input int ty, input int c, input bit keep, input string tag);
    int bc, b0;
    wr_q.delete();
    exp_q.delete();
    model_accept(tx, ty, c);
    touch_valid = 1'b1;
    touch_x     = 10'(tx);
    touch_y     = 10'(ty);
    pen_color   = 16'(c);
    @(negedge clk);
    b0 = (busy === 1'b1) ? 1 : 0;
    if (!keep) touch_valid = 1'b0;
    wait_quiet(1000, tag, bc);
    compare_writes(tag, 1'b1);
    check({tag, " pixel count"}, wr_q.size(), exp_px);
    check({tag, " busy cycles"}, b0 + bc, exp_px);
    if (!keep) pen_down_m = 1'b0;
  endtask

  task automatic pen_up();
    touch_valid = 1'b0;
    repeat (2) @(negedge clk);
    pen_down_m = 1'b0;
  endtask

  initial begin
    int bc, rx, ry, rc, base;
    bit rk;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset wr_ena", 32'(vram_wr_ena), 0);
    check("reset wr_addr", 32'(vram_wr_addr), 0);
    check("reset wr_data", 32'(vram_wr_data), 32'(BG));
    check("reset busy", 32'(busy), 1);

    // Power-on clear
    wr_q.delete();
    exp_q.delete();
    add_clear();
    rst = 1'b0;
    @(negedge clk);
    check("first clear write ena", 32'(vram_wr_ena), 1);
    check("first clear write addr", 32'(vram_wr_addr), 0);
    wait_quiet(VL + 100, "power-on clear", bc);
    compare_writes("power-on clear", 1'b1);
    check("post-clear busy", 32'(busy), 0);
    check("post-clear wr_ena", 32'(vram_wr_ena), 0);

    // Single dot, then a held stroke there and back
    stroke(10, 20, 16'hFFFF, 1'b1, "dot 10,20");
    check("dot addr", got_addr(0), 4810);
    check("dot data", (wr_q.size() > 0) ? wr_q[0].data : -1, 32'hFFFF);
    stroke(14, 22, 16'hFFFF, 1'b1, "line to 14,22");
    check("line pix0", got_addr(0), 4810);
    check("line pix1", got_addr(1), 5051);
    check("line pix2", got_addr(2), 5052);
    check("line pix3", got_addr(3), 5293);
    check("line pix4", got_addr(4), 5294);
    stroke(10, 20, 16'h07E0, 1'b1, "line back to 10,20");
    check("reverse first", got_addr(0), 5294);
    check("reverse last", got_addr(4), 4810);

    // Out-of-range sample clamps to the last pixel; a repeat is silent
    pen_up();
    stroke(300, 400, 16'hF800, 1'b1, "clamped corner");
    check("clamped corner addr", got_addr(0), VL - 1);
    stroke(300, 400, 16'hF800, 1'b1, "repeated corner");

    // Random strokes, mostly with the finger held
    for (int i = 0; i < 40; i++) begin
      rx = $urandom_range(0, 300);
      ry = $urandom_range(0, 40);
      rc = $urandom_range(0, 65535);
      rk = ($urandom_range(0, 3) != 0);
      stroke(rx, ry, rc, rk, "random stroke");
    end

    // Clear requested mid-line: line finishes, full clear, next sample is a lone dot
    pen_up();
    stroke(0, 0, 16'h001F, 1'b1, "mid-clear line start");
    wr_q.delete();
    exp_q.delete();
    model_accept(200, 23, 16'h001F);
    base = exp_q.size();
    add_clear();
    pen_down_m = 1'b0;
    model_accept(200, 23, 16'h001F);
    touch_x = 10'd200;
    touch_y = 10'd23;
    repeat (50) @(negedge clk);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    wait_quiet(VL + 1000, "clear mid-line", bc);
    compare_writes("clear mid-line", 1'b0);
    if (wr_q.size() >= base + VL)
      check("line+clear span", wr_q[base+VL-1].cyc - wr_q[0].cyc, base + VL - 1);
    else
      check("line+clear length", wr_q.size(), base + VL + 1);

    // Clear beats a simultaneous touch; a second request during the clear queues another
    wr_q.delete();
    exp_q.delete();
    add_clear();
    add_clear();
    touch_valid = 1'b1;
    touch_x     = 10'd50;
    touch_y     = 10'd10;
    clear_req   = 1'b1;
    @(negedge clk);
    clear_req   = 1'b0;
    touch_valid = 1'b0;
    repeat (100) @(negedge clk);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    wait_quiet(2 * VL + 200, "double clear", bc);
    compare_writes("double clear", 1'b1);
    pen_down_m = 1'b0;

    // Reset in the middle of a line
    stroke(0, 0, 16'hABCD, 1'b1, "reset line start");
    touch_x = 10'd239;
    touch_y = 10'd23;
    repeat (20) @(negedge clk);
    check("pre-reset write active", 32'(vram_wr_ena), 1);
    #1 rst = 1'b1;
    #1;
    check("async reset wr_ena", 32'(vram_wr_ena), 0);
    check("async reset wr_addr", 32'(vram_wr_addr), 0);
    check("async reset busy", 32'(busy), 1);
    touch_valid = 1'b0;
    repeat (2) @(negedge clk);
    wr_q.delete();
    exp_q.delete();
    add_clear();
    pen_down_m = 1'b0;
    rst = 1'b0;
    wait_quiet(VL + 100, "clear after reset", bc);
    compare_writes("clear after reset", 1'b1);
    stroke(5, 5, 16'h1234, 1'b0, "dot after reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vram_line_drawer.md
VRAM_LINE_DRAWER -- requirements
Module: vram_line_drawer

Interface
REQ-001 SHALL have parameter DISPLAY_WIDTH, 240, pixels per row.
REQ-002 SHALL have parameter DISPLAY_HEIGHT, 320, rows; VRAM_L = DISPLAY_WIDTH*DISPLAY_HEIGHT.
REQ-003 SHALL have parameter BG_COLOR, 16'h0000, clear colour (BLACK).
REQ-004 SHALL have port clk  input  1  single clock; all state on posedge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port touch_valid  input  1  finger down, level, sampled each cycle.
REQ-007 SHALL have port touch_x  input  10  touch column, unsigned.
REQ-008 SHALL have port touch_y  input  10  touch row, unsigned.
REQ-009 SHALL have port pen_color  input  16  ILI9341 colour for stroke pixels.
REQ-010 SHALL have port clear_req  input  1  one-cycle pulse requesting a full-screen clear.
REQ-011 SHALL have port vram_wr_ena  output  1  VRAM write strobe, one pixel per cycle.
REQ-012 SHALL have port vram_wr_addr  output  $clog2(VRAM_L)  write address = y*DISPLAY_WIDTH + x.
REQ-013 SHALL have port vram_wr_data  output  16  write pixel colour.
REQ-014 SHALL have port busy  output  1  high in CLEAR or LINE; touch samples not accepted.

Function
REQ-015 SHALL implement states CLEAR, IDLE, LINE; all outputs registered.
REQ-016 CLEAR: writes addresses 0..VRAM_L-1 ascending, one per cycle, data BG_COLOR, then IDLE; vram_wr_ena low on the cycle after the last write.
REQ-017 IDLE, touch_valid high, clear_req low: accept sample; clamp x to min(touch_x, DISPLAY_WIDTH-1), y to min(touch_y, DISPLAY_HEIGHT-1); latch pen_color.
REQ-018 Accept with pen_down low: single-pixel line (start = end = clamped point); go to LINE.
REQ-019 Accept with pen_down high: line from last endpoint to clamped point; go to LINE.
REQ-020 Accept with pen_down high and clamped point equal to last endpoint: no write, stay IDLE.
REQ-021 Every accept sets pen_down and stores the clamped point as last endpoint.
REQ-022 pen_down SHALL clear on any cycle, any state, with touch_valid low.
REQ-023 LINE: Bresenham, one pixel per cycle; dx=|x1-x0|, dy=-|y1-y0|, err=dx+dy, step sx/sy = +/-1; signed 12-bit err/dx/dy.
REQ-024 Per step: write (x,y); if (x,y)==(x1,y1) go to IDLE; else e2=2*err; if e2>=dy {err+=dy; x+=sx}; if e2<=dx {err+=dx; y+=sy}.
REQ-025 A line writes exactly max(|x1-x0|,|y1-y0|)+1 pixels on consecutive cycles; first write visible after the clock edge following the accepting edge.
REQ-026 Address computed as y*DISPLAY_WIDTH+x with no overflow for all clamped points; max address VRAM_L-1.
REQ-027 touch_valid samples during CLEAR or LINE SHALL be dropped, not queued.
REQ-028 clear_req in IDLE: enter CLEAR next cycle; takes priority over a simultaneous touch sample.
REQ-029 clear_req during LINE or CLEAR: latched; CLEAR starts at address 0 after the current operation ends.
REQ-030 Entering CLEAR SHALL clear pen_down.

Reset
REQ-031 rst high: immediately vram_wr_ena=0, vram_wr_addr=0, vram_wr_data=BG_COLOR, busy=1, pen_down=0, pending clear=0, state CLEAR.
REQ-032 After rst deasserts, first clear write (addr 0) on the first clock edge.
REQ-033 rst asserted mid-LINE or mid-CLEAR aborts the operation; clear restarts at address 0.

Verification
REQ-034 Reset release -> 76800 writes, addr 0..76799 ascending, data 0x0000, then busy=0, vram_wr_ena=0.
REQ-035 Pen up, sample (10,20), pen_color 0xFFFF -> one write addr 4810 data 0xFFFF; busy high one cycle.
REQ-036 After 035, hold touch_valid, sample (14,22) -> 5 writes addr 4810,5051,5052,5293,5294; reverse (14,22)->(10,20) -> 5 writes ending at 4810.
REQ-037 Pen up, sample (300,400) -> one write addr 76799; repeated identical sample with touch_valid held -> no write.
REQ-038 clear_req pulsed mid-line -> line completes fully, then 76800 BG_COLOR writes from addr 0; next sample is single-pixel (pen_down cleared).
REQ-039 rst asserted mid-line -> vram_wr_ena=0 asynchronously; on release, clear restarts at addr 0.
